// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : MIPS fetch stage. Holds a writable instruction memory and an
//             elastic prefetch FIFO with a valid/ready handshake toward
//             decode. A branch redirect flushes all prefetched entries.
//  Options  : FETCHQ_PERF_EN adds stall_cnt / flush_cnt performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int             XLEN       = 32,
    parameter int             IMEM_WORDS = 32,
    parameter int             QDEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          d_ready,
    output logic                          d_valid,
    output logic [31:0]                   d_inst,
    output logic [XLEN-1:0]               d_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   flush_cnt
`endif
);

    localparam int c_ADDR_W = $clog2(QDEPTH);
    localparam int c_IDX_W  = $clog2(IMEM_WORDS);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_QDEPTH = c_CNT_W'(QDEPTH);

    logic [31:0]         r_imem   [IMEM_WORDS];
    logic [31:0]         r_q_inst [QDEPTH];
    logic [XLEN-1:0]     r_q_pc   [QDEPTH];

    logic [XLEN-1:0]     r_fetch_pc;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_IDX_W-1:0]  w_imem_idx;
    logic [31:0]         w_fetch_inst;
    logic                w_pop;
    logic                w_push;

    // The two low bits of a branch target are dropped: fetch is word aligned.
    wire w_unused = &{1'b0, redirect_pc[1:0]};

    // Word index wraps modulo the memory depth by taking only the low bits.
    assign w_imem_idx   = r_fetch_pc[c_IDX_W+1:2];
    assign w_fetch_inst = r_imem[w_imem_idx];

    assign d_valid = (r_count != '0);
    assign w_pop   = d_valid & d_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign w_push  = ((r_count < c_QDEPTH) | w_pop) & ~redirect;

    // Head is presented straight from storage; an empty queue shows a nop.
    assign d_inst = d_valid ? r_q_inst[r_rd_ptr] : '0;
    assign d_pc   = d_valid ? r_q_pc[r_rd_ptr]   : '0;

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    // FIFO storage write; the stored PC is already the link value (PC + 4).
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q_inst[r_wr_ptr] <= w_fetch_inst;
            r_q_pc[r_wr_ptr]   <= r_fetch_pc + XLEN'(4);
        end
    end

    // Fetch PC, pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

`ifdef FETCHQ_PERF_EN
    // Saturating counters of decode back-pressure and of redirect cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (d_valid && !d_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. Expected head entries are
//             queued from a reference copy of the instruction memory when
//             reset/redirect stimulus is applied and compared on each pop.
//             Define FETCHQ_PERF_EN to also check the performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int XLEN       = 32;
    localparam int IMEM_WORDS = 32;
    localparam int QDEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        d_ready = 1'b0;
    logic        d_valid;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
`ifdef FETCHQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_queue #(
        .XLEN       (XLEN),
        .IMEM_WORDS (IMEM_WORDS),
        .QDEPTH     (QDEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_ready     (d_ready),
        .d_valid     (d_valid),
        .d_inst      (d_inst),
        .d_pc        (d_pc),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata)
`ifdef FETCHQ_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] ref_imem [IMEM_WORDS];
    logic [63:0] sb [$];
    int          n_checks = 0;
    int          n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the entries a correct fetch unit must deliver starting at pc.
    task automatic expect_seq(input logic [31:0] pc, input int n);
        logic [31:0] p;
        p = pc;
        for (int k = 0; k < n; k++) begin
            sb.push_back({ref_imem[p[6:2]], p + 32'd4});
            p = p + 32'd4;
        end
    endtask

    task automatic deliver();
        logic [63:0] e;
        if (sb.size() == 0) begin
            check("sb_underflow", {63'b0, d_valid}, 64'd0);
        end else begin
            e = sb.pop_front();
            check("d_inst", {32'b0, d_inst}, {32'b0, e[63:32]});
            check("d_pc",   {32'b0, d_pc},   {32'b0, e[31:0]});
        end
    endtask

    // Run n cycles with a fixed d_ready, consuming and checking each pop.
    task automatic run(input int n, input bit rdy, input bit gap_chk);
        for (int i = 0; i < n; i++) begin
            d_ready = rdy;
            if (gap_chk && sb.size() > 0) check("no_gap", {63'b0, d_valid}, 64'd1);
            if (d_valid && rdy) deliver();
            step();
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            case (i)
                0: ref_imem[i] = 32'h0000_0000;
                1: ref_imem[i] = 32'h200a_0005;
                2: ref_imem[i] = 32'h200b_0007;
                3: ref_imem[i] = 32'h200c_0002;
                4: ref_imem[i] = 32'h200d_0003;
                5: ref_imem[i] = 32'h014b_5020;
                default: ref_imem[i] = 32'h1000_0000 + i;
            endcase
        end

        // Preload memory while reset is held.
        rst = 1'b1;
        step();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 5'(i);
            imem_wdata = ref_imem[i];
            step();
        end
        imem_we = 1'b0;
        check("rst_valid", {63'b0, d_valid}, 64'd0);
        check("rst_inst",  {32'b0, d_inst},  64'd0);
        check("rst_pc",    {32'b0, d_pc},    64'd0);

        // 1: release reset with decode ready.
        rst     = 1'b0;
        d_ready = 1'b1;
        expect_seq(32'h0, 5);
        step();
        check("valid_rise", {63'b0, d_valid}, 64'd1);
        run(5, 1'b1, 1'b1);

        // 2: decode stalled for 10 cycles, then drain with no gap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("rst2_valid", {63'b0, d_valid}, 64'd0);
        run(10, 1'b0, 1'b0);
        check("full_head_pc", {32'b0, d_pc}, 64'd4);
        expect_seq(32'h0, 5);
        run(5, 1'b1, 1'b1);
        run(4, 1'b0, 1'b0);
        check("refill_head_pc", {32'b0, d_pc}, 64'h18);

        // 3: redirect with a full queue.
        pulse_redirect(32'h14);
        check("redir_gap", {63'b0, d_valid}, 64'd0);
        sb.delete();
        expect_seq(32'h14, 3);
        step();
        check("redir_inst", {32'b0, d_inst}, 64'h014b_5020);
        check("redir_pc",   {32'b0, d_pc},   64'h18);
        run(3, 1'b1, 1'b1);

        // 4: redirect concurrent with a pop; misaligned target.
        check("pre_redir_valid", {63'b0, d_valid}, 64'd1);
        d_ready = 1'b1;
        pulse_redirect(32'h16);
        check("redir2_gap", {63'b0, d_valid}, 64'd0);
        sb.delete();
        expect_seq(32'h14, 4);
        step();
        check("trunc_pc", {32'b0, d_pc}, 64'h18);
        run(4, 1'b1, 1'b1);

        // 5: reset mid-stream with 3 entries; memory write on the same edge
        //    as the first fetch of that word must yield the old data.
        d_ready = 1'b0;
        pulse_redirect(32'h0);
        run(3, 1'b0, 1'b0);
        check("three_head_pc", {32'b0, d_pc}, 64'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", {63'b0, d_valid}, 64'd0);
        check("rst_mid_inst",  {32'b0, d_inst},  64'd0);
        sb.delete();
        expect_seq(32'h0, 6);
        d_ready    = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = 5'd0;
        imem_wdata = 32'hdead_beef;
        step();
        imem_we     = 1'b0;
        ref_imem[0] = 32'hdead_beef;
        run(6, 1'b1, 1'b1);

        // Memory index wraps; the new word 0 is now visible.
        pulse_redirect(32'h80);
        sb.delete();
        expect_seq(32'h80, 3);
        step();
        run(3, 1'b1, 1'b1);

        // PC wraps at 2^32.
        pulse_redirect(32'hffff_fff8);
        sb.delete();
        expect_seq(32'hffff_fff8, 4);
        step();
        run(4, 1'b1, 1'b1);

        // 6: 10 stall cycles, then three back-to-back redirects (last wins).
        rst = 1'b1;
        step();
        rst     = 1'b0;
        d_ready = 1'b0;
        sb.delete();
        step();
        run(10, 1'b0, 1'b0);
        d_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h44;
        step();
        redirect_pc = 32'h08;
        step();
        redirect = 1'b0;
        check("b2b_gap", {63'b0, d_valid}, 64'd0);
        expect_seq(32'h08, 3);
        step();
        run(3, 1'b1, 1'b1);
`ifdef FETCHQ_PERF_EN
        check("stall_cnt", {32'b0, stall_cnt}, 64'd10);
        check("flush_cnt", {32'b0, flush_cnt}, 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised next-generation fetch stage for the MIPS pipeline. It replaces the fixed PC + instruction ROM + IF/ID register with an instruction memory of configurable depth and an elastic prefetch FIFO of configurable depth. It adds a valid/ready handshake toward decode, so decode can stall without losing instructions. A branch redirect from the memory stage flushes all prefetched work.

Parameters:
XLEN, 32, datapath and PC width
IMEM_WORDS, 32, instruction memory depth in words; power of 2
QDEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect  in  1  branch taken (pc_src); flush and reload PC
redirect_pc  in  XLEN  branch target (add_res)
d_ready  in  1  decode accepts head entry this cycle
d_valid  out  1  head entry valid
d_inst  out  32  head instruction
d_pc  out  XLEN  head instruction address + 4
imem_we  in  1  instruction memory write enable
imem_waddr  in  $clog2(IMEM_WORDS)  word address for the write
imem_wdata  in  32  write data

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst is sampled on posedge clk.
- Reset state: fetch_pc=RESET_PC; FIFO count, rd_ptr and wr_ptr = 0; d_valid=0; d_inst=0; d_pc=0.
- rst has priority over every other input, including a reset asserted mid-stream with a non-empty FIFO. Instruction memory contents are not cleared by reset.
- IMEM read:
  - Combinational, index fetch_pc[$clog2(IMEM_WORDS)+1:2].
  - Addresses beyond the memory wrap modulo IMEM_WORDS.
  - fetch_pc bits [1:0] are always 0.
- IMEM write: takes effect at posedge. A same-cycle read of the same word returns the old data.
- pop = d_valid & d_ready.
- push = (count<QDEPTH | pop) & ~redirect.
  - On push: the entry {imem[fetch_pc], fetch_pc+4} is written at wr_ptr, and fetch_pc advances by 4.
  - fetch_pc wraps naturally at 2^XLEN.
- Full FIFO: push only when pop occurs in the same cycle. Otherwise fetch_pc holds, with no drop and no duplicate.
- Empty FIFO: d_valid=0, and d_inst/d_pc are driven to 0 (nop). d_ready is ignored.
- Head outputs are read combinationally from FIFO storage at rd_ptr. d_valid = (count!=0).
- Latency: an instruction pushed at edge N is visible on d_* after edge N. With an empty FIFO, the first instruction after reset release appears 1 cycle after the first non-reset edge.
- Throughput: 1 instruction per cycle while d_ready=1.
- Redirect handling, on a posedge with redirect=1:
  - count, rd_ptr and wr_ptr are cleared; no push occurs; a concurrent pop is discarded.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, so a misaligned target is truncated.
  - In the next cycle d_valid=0. The target instruction is valid one cycle after that.
- Back-to-back redirects: each one reloads fetch_pc; the last one wins.
- Pointers are $clog2(QDEPTH) bits and wrap naturally. count is $clog2(QDEPTH)+1 bits.

Optional Feature:
FETCHQ_PERF_EN
- Defined: adds two output ports.
  - stall_cnt (32): counts cycles with d_valid=1 and d_ready=0.
  - flush_cnt (32): counts redirect cycles, including those where the FIFO is empty.
  - Both counters reset to 0 on rst and saturate at 2^32-1.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
1. Preload imem[0..4] = 00000000, 200a0005, 200b0007, 200c0002, 200d0003; release rst with d_ready=1.
   -> d_valid rises 1 cycle after release.
   -> d_inst follows that sequence on consecutive cycles, with d_pc = 4, 8, 12, 16, 20.
2. Hold d_ready=0 for 10 cycles after reset.
   -> FIFO fills to 4 entries and fetch_pc holds at 16.
   -> On d_ready=1: imem[0..4] emerge in order, with no gap and no duplicate.
3. With the FIFO full, pulse redirect=1 with redirect_pc=0x14 and imem[5]=014b5020.
   -> Next cycle: d_valid=0.
   -> Following cycle: d_inst=014b5020, d_pc=0x18.
4. Assert redirect=1 and d_ready=1 while d_valid=1, redirect_pc=0x16.
   -> The popped entry is not re-delivered.
   -> Next valid entry is at PC 0x14 with d_pc=0x18 (misaligned target truncated).
5. Assert rst for 1 cycle while the FIFO holds 3 entries.
   -> Next cycle: d_valid=0.
   -> Fetch restarts at RESET_PC and imem contents are preserved.
6. With FETCHQ_PERF_EN defined, run scenario 2, then 3 redirects.
   -> stall_cnt=10.
   -> flush_cnt=3.
